pipeline_hazard_ctrl: RTL

Parametrised hazard and forwarding controller for the 5-stage pipeline (IF, ID, EX, DM, WB). It keeps an internal shadow of the destination and control bits for instructions in EX, DM and WB. From that shadow it produces:
- stall, bubble and flush controls for the IF_ID and ID_EX registers;
- ALU operand forwarding selects;
- the WB-to-ID register-file bypass.

It extends the existing fixed interlock flags with:
- configurable register-address width;
- configurable load-use penalty;
- branch squash.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/hazard_fwd_mux_sel.sv | 14 +
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared forwarding codes, FSM states and shadow-slot type for pipeline_hazard_ctrl.
package pipeline_pkg;
  localparam int MAX_AW = 16;
  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_WB = 2'b01;
  localparam logic [1:0] FWD_EXDM = 2'b10;
  typedef enum logic {RUN, LU_WAIT} state_t;
  typedef struct packed {
    logic valid;
    logic [MAX_AW-1:0] rd;
    logic reg_write;
    logic mem_read;
    logic [MAX_AW-1:0] rs;
    logic [MAX_AW-1:0] rt;
    logic uses_rs;
    logic uses_rt;
  } slot_t;
  // r0 is hard-wired zero, so it never produces a dependency
  function automatic logic reg_hit(input logic en, input logic [MAX_AW-1:0] rd, input logic [MAX_AW-1:0] src);
    return en && src == rd && src != '0;
  endfunction
endpackage

// File: rtl/hazard_fwd_mux_sel.sv
// hazard_fwd_mux_sel: forwarding select for one EX operand; the DM producer is newer and wins over WB.
module hazard_fwd_mux_sel
  import pipeline_pkg::*;
(
  input  logic [MAX_AW-1:0] i_src,
  input  logic              i_dm_en,
  input  logic [MAX_AW-1:0] i_dm_rd,
  input  logic              i_wb_en,
  input  logic [MAX_AW-1:0] i_wb_rd,
  output logic [1:0]        o_sel
);
  always_comb o_sel = reg_hit(i_dm_en, i_dm_rd, i_src) ? FWD_EXDM :
                      reg_hit(i_wb_en, i_wb_rd, i_src) ? FWD_WB : FWD_REGFILE;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/bubble/flush, forwarding and WB bypass control for a 5-stage pipeline.
// HAZ_FORWARD_EN enables forwarding and bypass; without it the block is interlock-only.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int LU_STALL = 1,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_branch_taken,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              id_bypass_rs,
  output logic              id_bypass_rt
);
  slot_t r_ex, r_dm, r_wb, w_id;
  state_t r_state, w_state_nx;
  logic [CNT_W-1:0] r_stall_cnt, w_cnt_nx;
  logic [MAX_AW-1:0] w_rs, w_rt;
  logic [1:0] w_fwd_a, w_fwd_b;
  logic w_ex_wr, w_dm_wr, w_dm_fwd, w_wb_wr, w_lu_haz, w_raw_haz, w_stall, w_issue, w_unused;

  assign w_rs = MAX_AW'(id_rs);
  assign w_rt = MAX_AW'(id_rt);
  assign w_id = '{valid: 1'b1, rd: MAX_AW'(id_rd), reg_write: id_reg_write, mem_read: id_mem_read,
                  rs: w_rs, rt: w_rt, uses_rs: id_uses_rs, uses_rt: id_uses_rt};
  assign w_ex_wr = r_ex.valid & r_ex.reg_write;
  assign w_dm_wr = r_dm.valid & r_dm.reg_write;
  assign w_dm_fwd = w_dm_wr & ~r_dm.mem_read;
  assign w_wb_wr = r_wb.valid & r_wb.reg_write;
  assign w_lu_haz = id_valid & r_ex.mem_read & (id_uses_rs & reg_hit(w_ex_wr, r_ex.rd, w_rs) |
                                                id_uses_rt & reg_hit(w_ex_wr, r_ex.rd, w_rt));

  hazard_fwd_mux_sel u_fwd_a (.i_src(r_ex.rs), .i_dm_en(w_dm_fwd), .i_dm_rd(r_dm.rd),
                              .i_wb_en(w_wb_wr), .i_wb_rd(r_wb.rd), .o_sel(w_fwd_a));
  hazard_fwd_mux_sel u_fwd_b (.i_src(r_ex.rt), .i_dm_en(w_dm_fwd), .i_dm_rd(r_dm.rd),
                              .i_wb_en(w_wb_wr), .i_wb_rd(r_wb.rd), .o_sel(w_fwd_b));

`ifdef HAZ_FORWARD_EN
  assign w_raw_haz = 1'b0;
  assign fwd_a_sel = w_fwd_a;
  assign fwd_b_sel = w_fwd_b;
  assign id_bypass_rs = id_uses_rs & reg_hit(w_wb_wr, r_wb.rd, w_rs);
  assign id_bypass_rt = id_uses_rt & reg_hit(w_wb_wr, r_wb.rd, w_rt);
`else
  // WB producers are safe: the register file writes before ID reads in the same cycle
  assign w_raw_haz = id_valid & (id_uses_rs & (reg_hit(w_ex_wr, r_ex.rd, w_rs) | reg_hit(w_dm_wr, r_dm.rd, w_rs)) |
                                 id_uses_rt & (reg_hit(w_ex_wr, r_ex.rd, w_rt) | reg_hit(w_dm_wr, r_dm.rd, w_rt)));
  assign fwd_a_sel = FWD_REGFILE;
  assign fwd_b_sel = FWD_REGFILE;
  assign id_bypass_rs = 1'b0;
  assign id_bypass_rt = 1'b0;
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_stall_cnt;
    w_stall = 1'b0;
    if (ex_branch_taken) begin
      w_state_nx = RUN;
      w_cnt_nx = '0;
    end else if (r_state == LU_WAIT) begin
      w_stall = 1'b1;
      w_cnt_nx = r_stall_cnt - 1'b1;
      w_state_nx = (r_stall_cnt == CNT_W'(1)) ? RUN : LU_WAIT;
    end else begin
      w_stall = w_lu_haz | w_raw_haz;
      if (w_lu_haz) begin
        w_cnt_nx = CNT_W'(LU_STALL - 1);
        w_state_nx = (LU_STALL > 1) ? LU_WAIT : RUN;
      end
    end
  end

  assign stall_if = w_stall;
  assign stall_id = w_stall;
  assign bubble_ex = w_stall | ex_branch_taken;
  assign flush_if_id = ex_branch_taken;
  assign w_issue = id_valid & ~stall_id & ~flush_if_id;
  assign w_unused = ^{r_ex, r_dm, r_wb, w_fwd_a, w_fwd_b};

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_ex <= '0;
      r_dm <= '0;
      r_wb <= '0;
      r_state <= RUN;
      r_stall_cnt <= '0;
    end else begin
      r_wb <= r_dm;
      r_dm <= r_ex;
      r_ex <= w_issue ? w_id : '0;
      r_state <= w_state_nx;
      r_stall_cnt <= w_cnt_nx;
    end
endmodule
